// File: rtl/av_master_arbiter.sv
// Two-requester Avalon-MM master arbiter: round-robin, one whole transaction per grant,
// with a watchdog that force-completes transfers the slave never acknowledges.
module av_master_arbiter #(
    parameter int unsigned             ADDR_WIDTH   = 16,
    parameter int unsigned             DATA_WIDTH   = 16,
    parameter int unsigned             TIMEOUT      = 1024,
    parameter logic [DATA_WIDTH-1:0]   TIMEOUT_DATA = 16'hDEAD
) (
    input  logic                  sysclk,
    input  logic                  sysreset_n,

    input  logic [ADDR_WIDTH-1:0] r0_address,
    input  logic [DATA_WIDTH-1:0] r0_writedata,
    input  logic                  r0_write,
    input  logic                  r0_read,
    output logic                  r0_waitrequest,
    output logic [DATA_WIDTH-1:0] r0_readdata,

    input  logic [ADDR_WIDTH-1:0] r1_address,
    input  logic [DATA_WIDTH-1:0] r1_writedata,
    input  logic                  r1_write,
    input  logic                  r1_read,
    output logic                  r1_waitrequest,
    output logic [DATA_WIDTH-1:0] r1_readdata,

    output logic [ADDR_WIDTH-1:0] m_address,
    output logic [DATA_WIDTH-1:0] m_writedata,
    output logic                  m_write,
    output logic                  m_read,
    input  logic                  m_waitrequest,
    input  logic [DATA_WIDTH-1:0] m_readdata,

    output logic                  timeout_flag,
    input  logic                  timeout_clr,
    output logic                  grant_id
);

    localparam int unsigned      CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_e;

    state_e           state_q, state_d;
    logic             grant_id_q, grant_id_d;
    logic             last_grant_q, last_grant_d;
    logic             timeout_flag_q, timeout_flag_d;
    logic [CNT_W-1:0] counter_q, counter_d;

    logic                  r0_req, r1_req;
    logic                  busy, timed_out, complete;
    logic                  sel_write, sel_read;
    logic [ADDR_WIDTH-1:0] sel_address;
    logic [DATA_WIDTH-1:0] sel_writedata;

    assign r0_req = r0_write | r0_read;
    assign r1_req = r1_write | r1_read;

    assign sel_address   = grant_id_q ? r1_address   : r0_address;
    assign sel_writedata = grant_id_q ? r1_writedata : r0_writedata;
    assign sel_write     = grant_id_q ? r1_write     : r0_write;
    assign sel_read      = grant_id_q ? r1_read      : r0_read;

    assign busy      = (state_q == ST_BUSY);
    assign timed_out = busy && m_waitrequest && (counter_q == CNT_LAST);
    assign complete  = busy && (!m_waitrequest || timed_out);

    // Strobes are gated by state so a reset drops them without waiting for a clock.
    assign m_address   = sel_address;
    assign m_writedata = sel_writedata;
    assign m_write     = busy & sel_write;
    assign m_read      = busy & sel_read & ~sel_write;

    assign timeout_flag = timeout_flag_q;
    assign grant_id     = grant_id_q;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        r0_waitrequest = 1'b1;
        r1_waitrequest = 1'b1;
        r0_readdata    = '0;
        r1_readdata    = '0;
        if (busy) begin
            if (grant_id_q) begin
                r1_waitrequest = ~complete;
                r1_readdata    = timed_out ? TIMEOUT_DATA : m_readdata;
            end else begin
                r0_waitrequest = ~complete;
                r0_readdata    = timed_out ? TIMEOUT_DATA : m_readdata;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_id_d     = grant_id_q;
        last_grant_d   = last_grant_q;
        counter_d      = counter_q;
        timeout_flag_d = timeout_flag_q;

        // A forced completion wins over a clear arriving in the same cycle.
        if (timed_out) begin
            timeout_flag_d = 1'b1;
        end else if (timeout_clr) begin
            timeout_flag_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (r0_req || r1_req) begin
                    grant_id_d = (r0_req && r1_req) ? ~last_grant_q : r1_req;
                    counter_d  = '0;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (complete) begin
                    last_grant_d = grant_id_q;
                    counter_d    = '0;
                    state_d      = ST_DONE;
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            state_q        <= ST_IDLE;
            grant_id_q     <= 1'b0;
            last_grant_q   <= 1'b1;
            timeout_flag_q <= 1'b0;
            counter_q      <= '0;
        end else begin
            state_q        <= state_d;
            grant_id_q     <= grant_id_d;
            last_grant_q   <= last_grant_d;
            timeout_flag_q <= timeout_flag_d;
            counter_q      <= counter_d;
        end
    end

endmodule

// File: tb/tb_av_master_arbiter.sv
// Self-checking bench for av_master_arbiter: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_av_master_arbiter;

    localparam int          AW  = 16;
    localparam int          DW  = 16;
    localparam int          TO  = 8;
    localparam logic [15:0] TOD = 16'hDEAD;

    logic sysclk = 1'b0;
    logic sysreset_n = 1'b0;

    logic [1:0]         r_wr = '0;
    logic [1:0]         r_rd = '0;
    logic [1:0][AW-1:0] r_addr = '0;
    logic [1:0][DW-1:0] r_wdata = '0;

    logic          r0_waitrequest, r1_waitrequest;
    logic [DW-1:0] r0_readdata, r1_readdata;
    logic [AW-1:0] m_address;
    logic [DW-1:0] m_writedata;
    logic          m_write, m_read;
    logic          m_waitrequest = 1'b1;
    logic [DW-1:0] m_readdata = '0;
    logic          timeout_flag;
    logic          timeout_clr = 1'b0;
    logic          grant_id;

    av_master_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .TIMEOUT      (TO),
        .TIMEOUT_DATA (TOD)
    ) dut (
        .sysclk         (sysclk),
        .sysreset_n     (sysreset_n),
        .r0_address     (r_addr[0]),
        .r0_writedata   (r_wdata[0]),
        .r0_write       (r_wr[0]),
        .r0_read        (r_rd[0]),
        .r0_waitrequest (r0_waitrequest),
        .r0_readdata    (r0_readdata),
        .r1_address     (r_addr[1]),
        .r1_writedata   (r_wdata[1]),
        .r1_write       (r_wr[1]),
        .r1_read        (r_rd[1]),
        .r1_waitrequest (r1_waitrequest),
        .r1_readdata    (r1_readdata),
        .m_address      (m_address),
        .m_writedata    (m_writedata),
        .m_write        (m_write),
        .m_read         (m_read),
        .m_waitrequest  (m_waitrequest),
        .m_readdata     (m_readdata),
        .timeout_flag   (timeout_flag),
        .timeout_clr    (timeout_clr),
        .grant_id       (grant_id)
    );

    always #10 sysclk = ~sysclk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: who owns the bus (-1 = nobody), how long they have waited,
    // whether the mandatory turnaround cycle is pending, and the fairness history.
    int   mdl_owner;
    int   mdl_age;
    bit   mdl_turn;
    int   mdl_last;
    logic mdl_gid;
    logic mdl_flag;

    bit   acc [2];
    int   mw_cnt;
    int   dut_order[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        mdl_owner = -1;
        mdl_age   = 0;
        mdl_turn  = 1'b0;
        mdl_last  = 1;
        mdl_gid   = 1'b0;
        mdl_flag  = 1'b0;
        acc[0]    = 1'b0;
        acc[1]    = 1'b0;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic tick();
        bit         tmo;
        logic [1:0] req;
        int         pick;
        @(posedge sysclk);
        #1;
        tmo = (mdl_owner >= 0) && m_waitrequest && (mdl_age == TO - 1);
        if (tmo) mdl_flag = 1'b1;
        else if (timeout_clr) mdl_flag = 1'b0;
        if (mdl_turn) begin
            mdl_turn = 1'b0;
        end else if (mdl_owner >= 0) begin
            if (!m_waitrequest || tmo) begin
                mdl_last  = mdl_owner;
                mdl_owner = -1;
                mdl_turn  = 1'b1;
            end else begin
                mdl_age++;
            end
        end else begin
            req = r_wr | r_rd;
            if (req == 2'b11)  pick = 1 - mdl_last;
            else if (req[0])   pick = 0;
            else if (req[1])   pick = 1;
            else               pick = -1;
            if (pick >= 0) begin
                mdl_owner = pick;
                mdl_gid   = pick[0];
                mdl_age   = 0;
            end
        end
    endtask

    task automatic check_outputs();
        bit            busy, tmo, done_now, own;
        int            g;
        logic          exp_wq;
        logic [DW-1:0] exp_rd;
        #1;
        busy     = (mdl_owner >= 0);
        g        = busy ? mdl_owner : 0;
        tmo      = busy && m_waitrequest && (mdl_age == TO - 1);
        done_now = busy && (!m_waitrequest || tmo);
        check("m_write", 32'(m_write), 32'(busy && r_wr[g]));
        check("m_read",  32'(m_read),  32'(busy && r_rd[g] && !r_wr[g]));
        if (busy) begin
            check("m_address",   32'(m_address),   32'(r_addr[g]));
            check("m_writedata", 32'(m_writedata), 32'(r_wdata[g]));
        end
        for (int i = 0; i < 2; i++) begin
            own    = busy && (g == i);
            exp_wq = !(own && done_now);
            exp_rd = own ? (tmo ? TOD : m_readdata) : '0;
            acc[i] = own && done_now;
            if (i == 0) begin
                check("r0_waitrequest", 32'(r0_waitrequest), 32'(exp_wq));
                check("r0_readdata",    32'(r0_readdata),    32'(exp_rd));
            end else begin
                check("r1_waitrequest", 32'(r1_waitrequest), 32'(exp_wq));
                check("r1_readdata",    32'(r1_readdata),    32'(exp_rd));
            end
        end
        check("grant_id",     32'(grant_id),     32'(mdl_gid));
        check("timeout_flag", 32'(timeout_flag), 32'(mdl_flag));
        if (m_write) mw_cnt++;
        if (!r0_waitrequest) dut_order.push_back(0);
        if (!r1_waitrequest) dut_order.push_back(1);
    endtask

    task automatic step();
        check_outputs();
        tick();
    endtask

    task automatic do_reset();
        sysreset_n = 1'b0;
        #1;
        mdl_reset();
        check_outputs();
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        sysreset_n = 1'b1;
        tick();
    endtask

    task automatic new_cmd(input int i);
        int kind;
        kind       = $urandom_range(0, 2);
        r_addr[i]  = AW'($urandom);
        r_wdata[i] = DW'($urandom);
        r_wr[i]    = (kind != 1);
        r_rd[i]    = (kind != 0);
    endtask

    initial begin
        bit stuck;
        int budget;
        int exp_order [4];

        // Reset state
        do_reset();

        // Single write with three slave wait cycles
        mw_cnt = 0;
        r_addr[0] = 16'h0010; r_wdata[0] = 16'h1234; r_wr[0] = 1'b1;
        m_waitrequest = 1'b1;
        step();
        repeat (3) step();
        m_waitrequest = 1'b0;
        step();
        r_wr[0] = 1'b0;
        step();
        step();
        check("single_write_mwrite_cycles", 32'(mw_cnt), 32'd4);

        // Read pass-through on requester 1
        r_addr[1] = 16'h0020; r_rd[1] = 1'b1;
        step();
        m_readdata = 16'hBEEF;
        check_outputs();
        check("read_r1_readdata", 32'(r1_readdata), 32'hBEEF);
        check("read_grant_id",    32'(grant_id),    32'd1);
        tick();
        r_rd[1] = 1'b0;
        step();
        step();

        // Contention straight after reset: strict 0,1,0,1
        r_wr = 2'b11; r_addr[0] = 16'h0100; r_addr[1] = 16'h0200;
        m_waitrequest = 1'b0;
        do_reset();
        dut_order.delete();
        budget = 0;
        while (dut_order.size() < 4 && budget < 40) begin
            r_wdata[0] = DW'($urandom);
            r_wdata[1] = DW'($urandom);
            step();
            budget++;
        end
        check("contention_count", 32'(dut_order.size()), 32'd4);
        exp_order = '{0, 1, 0, 1};
        for (int k = 0; k < 4 && k < dut_order.size(); k++)
            check("contention_order", 32'(dut_order[k]), 32'(exp_order[k]));
        r_wr = 2'b00;
        repeat (3) step();

        // Timeout on a read that the slave never acknowledges
        m_waitrequest = 1'b1;
        r_addr[0] = 16'h0040; r_rd[0] = 1'b1;
        step();
        repeat (7) step();
        check_outputs();
        check("timeout_r0_readdata", 32'(r0_readdata), 32'(TOD));
        tick();
        r_rd[0] = 1'b0;
        repeat (3) step();
        check("timeout_flag_sticky", 32'(timeout_flag), 32'd1);
        timeout_clr = 1'b1;
        step();
        timeout_clr = 1'b0;
        step();
        check("timeout_flag_cleared", 32'(timeout_flag), 32'd0);

        // Write and read together: a write wins
        r_wr[0] = 1'b1; r_rd[0] = 1'b1; r_addr[0] = 16'h0050;
        m_waitrequest = 1'b0;
        step();
        check_outputs();
        check("wr_rd_m_write", 32'(m_write), 32'd1);
        check("wr_rd_m_read",  32'(m_read),  32'd0);
        tick();
        r_wr[0] = 1'b0; r_rd[0] = 1'b0;
        repeat (2) step();

        // Asynchronous reset in the middle of a transfer
        m_waitrequest = 1'b1;
        r_wr[0] = 1'b1; r_addr[0] = 16'h0060;
        step();
        step();
        #4;
        r_rd[1] = 1'b1;
        do_reset();
        check_outputs();
        check("post_reset_tie_grant", 32'(grant_id), 32'd0);
        tick();
        r_wr = 2'b00; r_rd = 2'b00;
        m_waitrequest = 1'b0;
        repeat (4) step();

        // Randomized traffic
        stuck = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) begin
                    if ($urandom_range(0, 1) == 1) new_cmd(i);
                    else begin r_wr[i] = 1'b0; r_rd[i] = 1'b0; end
                end else if (!(r_wr[i] | r_rd[i]) && $urandom_range(0, 2) == 0) begin
                    new_cmd(i);
                end
            end
            if ($urandom_range(0, 40) == 0) stuck = ~stuck;
            m_waitrequest = stuck ? 1'b1 : ($urandom_range(0, 3) != 0);
            m_readdata    = DW'($urandom);
            timeout_clr   = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/av_master_arbiter.md
Name: av_master_arbiter

Overview:
- Shares the single Qsys generic Avalon-MM master port between two requesters: the target MCU's memory-mapped Avalon registers (requester 0) and the debug supervisor's dbg_av_* master (requester 1).
- Each side sees a standard Avalon-MM master interface with its own waitrequest.
- The arbiter grants one complete transaction at a time, round-robin between the two requesters.
- A watchdog force-completes transactions the slave never acknowledges, so the MCU (stalled via mcu_wait) cannot hang forever.

Parameters:
ADDR_WIDTH, 16, address width of all ports
DATA_WIDTH, 16, data width of all ports
TIMEOUT, 1024, slave-wait cycles before forced completion (range 2..65535)
TIMEOUT_DATA, 16'hDEAD, readdata returned on a timed-out read

Ports:
sysclk  in  1  system clock (50 MHz)
sysreset_n  in  1  asynchronous active-low reset
r0_address  in  ADDR_WIDTH  requester 0 (MCU) address
r0_writedata  in  DATA_WIDTH  requester 0 write data
r0_write  in  1  requester 0 write request
r0_read  in  1  requester 0 read request
r0_waitrequest  out  1  stall to requester 0
r0_readdata  out  DATA_WIDTH  read data to requester 0
r1_address, r1_writedata, r1_write, r1_read, r1_waitrequest, r1_readdata  (same widths and directions)  requester 1 (debug supervisor)
m_address  out  ADDR_WIDTH  to Qsys m0_address
m_writedata  out  DATA_WIDTH  to Qsys m0_writedata
m_write  out  1  to Qsys m0_write
m_read  out  1  to Qsys m0_read
m_waitrequest  in  1  from Qsys m0_waitrequest
m_readdata  in  DATA_WIDTH  from Qsys m0_readdata
timeout_flag  out  1  sticky: a forced completion occurred
timeout_clr  in  1  synchronous clear of timeout_flag
grant_id  out  1  requester owning the current or most recent transaction

Behaviour:
- Reset (async assert, sync deassert by the top level):
  - state=IDLE, last_grant=1 (so requester 0 wins the first tie), grant_id=0, timeout_flag=0, counter=0.
  - m_write=m_read=0 immediately, because master strobes are gated by state.
  - r0_waitrequest=r1_waitrequest=1.
- Request: rN_req = rN_write | rN_read. If both are high on one requester, it is a write and the read is ignored for that transaction.
- States IDLE, BUSY, DONE.
- IDLE:
  - If exactly one request: grant it.
  - If both: grant the one not equal to last_grant.
  - Register grant_id and move to BUSY next edge. Arbitration latency is 1 cycle.
  - No master strobes are driven in IDLE.
- BUSY:
  - m_address/m_writedata/m_write/m_read = granted requester's inputs, combinational mux on grant_id.
  - The requester must hold its command stable until its waitrequest drops.
  - The granted requester's waitrequest = m_waitrequest, and its readdata = m_readdata (pass-through).
  - When m_waitrequest=0: the transaction completes in that cycle; last_grant<=grant_id; counter<=0; state<=DONE.
  - Otherwise counter increments.
  - If counter==TIMEOUT-1 with m_waitrequest still 1: force completion that cycle.
    - Granted waitrequest=0; readdata=TIMEOUT_DATA.
    - timeout_flag<=1; master strobes still asserted that cycle; state<=DONE.
- DONE: one turnaround cycle. No strobes; both waitrequests=1; state<=IDLE. This lets the requester deassert or present a new command.
- Non-granted requester: waitrequest=1 at all times; readdata=0.
- Fairness: back-to-back contention alternates strictly 0,1,0,1. A lone requester is re-granted every 3 cycles (IDLE, BUSY, DONE) with zero-wait slaves.
- Requester drops its request while in BUSY (protocol violation): master strobes follow the inputs and drop; the arbiter remains in BUSY until waitrequest=0 or timeout. Not otherwise detected.
- timeout_flag: set has priority over timeout_clr in the same cycle.
- Reset mid-BUSY: transaction abandoned, strobes drop combinationally with reset; no completion is signalled.

Test Plan:
- Single write: r0 write addr 0x0010 data 0x1234, slave waitrequest 1 for 3 cycles -> m_write high 4 cycles with r0 values; r0_waitrequest falls in 4th BUSY cycle; r1_waitrequest stays 1.
- Read pass-through: r1 read addr 0x0020, slave returns 0xBEEF with waitrequest 0 on the first BUSY cycle -> r1_readdata=0xBEEF in that cycle; grant_id=1.
- Contention: r0 and r1 request in the same cycle after reset -> r0 served first, then r1. Keep both requesting for 4 transactions -> order 0,1,0,1; never both granted.
- Timeout: TIMEOUT=8, slave holds waitrequest=1 -> after 8 BUSY cycles r0_waitrequest=0, r0_readdata=0xDEAD, timeout_flag=1. It stays set until timeout_clr, which clears it next cycle.
- Write+read simultaneous: r0_write=r0_read=1 -> m_write=1, m_read=0.
- Async reset mid-BUSY: pull sysreset_n low while m_write=1 -> m_write=0 in the same cycle without a clock; after release the arbiter is in IDLE and grants r0 on a tie.
